bp_train_scheduler: RTL and testbench
=====================================

# bp_train_scheduler

Training scheduler for the perceptron branch predictor. It holds a small in-order queue of in-flight predictions (table index, perceptron output y, history snapshot). When a branch resolves, it decides whether the perceptron needs training. If so, it writes the per-weight ±1 deltas into the shared weight table one weight per cycle, taking the table port only when the lookup path grants it. It sits between the fetch-side predictor lookup and the execute-side branch resolution.

## Interface
- NW, 9, weights per perceptron (bit 0 of history is the bias input, always 1)
- IDXW, 6, table index width
- YW, 16, signed width of perceptron output y
- DEPTH, 4, in-flight queue entries (power of two)
- THRESHOLD, 133, training threshold on |y|
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pred_valid  in  1  push a new prediction record
- pred_ready  out  1  queue not full
- pred_index  in  IDXW  table index used for the prediction
- pred_y  in  YW  signed perceptron output
- pred_hist  in  NW  history vector; bit i=1 means x_i=+1, 0 means x_i=-1
- res_valid  in  1  outcome of the oldest in-flight branch
- res_ready  out  1  resolution accepted this cycle
- res_taken  in  1  actual branch direction
- tbl_req  out  1  scheduler wants the table write port
- tbl_grant  in  1  lookup path yields the port this cycle
- tbl_we  out  1  weight update strobe
- tbl_index  out  IDXW  entry being trained
- tbl_widx  out  4  weight number, 0..NW-1
- tbl_delta  out  2  signed update, +1 (2'b01) or -1 (2'b11)
- busy  out  1  state is TRAIN
- count  out  $clog2(DEPTH)+1  queue occupancy
- mispredict_cnt  out  16  saturating count of resolved mispredictions

## Operation
- Queue: circular FIFO with wrapping read and write pointers.
  - Push when pred_valid && pred_ready. pred_ready = (count != DEPTH). There is no bypass when full.
  - Pop when res_valid && res_ready. res_ready = (state==IDLE) && (count != 0).
  - Push and pop in the same cycle are both performed; count is unchanged.
- Decision on pop, using the head record:
  - predicted = ($signed(y) > 0).
  - mispredict = (res_taken != predicted).
  - low_conf = (-THRESHOLD < y < THRESHOLD), strict on both sides.
  - train = mispredict || low_conf.
  - On mispredict, mispredict_cnt increments and saturates at 16'hFFFF.
- State machine:
  - IDLE: on pop with train=1, latch index, hist and t (+1 if taken, else -1). Clear weight counter k to 0. Go to TRAIN.
  - IDLE: on pop with train=0, stay in IDLE.
  - TRAIN: tbl_req=1. On each cycle with tbl_grant=1, assert tbl_we with tbl_widx=k and tbl_delta=t·x_k, then k++. After the write with k=NW-1, go to IDLE.
  - TRAIN: a cycle with tbl_grant=0 holds k and produces no write.
- Saturation of weights is the table's responsibility; the scheduler only issues deltas.
- Reset (asynchronous, at any time, including mid-TRAIN):
  - state=IDLE, pointers, count and k cleared, mispredict_cnt=0.
  - The partially trained entry is abandoned; no further writes occur.

## Timing
- Reset values:
  - pred_ready=1, res_ready=0, tbl_req=0, tbl_we=0, busy=0, count=0, mispredict_cnt=0.
  - tbl_index, tbl_widx and tbl_delta are 0.
- tbl_we = busy && tbl_grant, combinational from the grant. The table commits on the same rising edge.
- tbl_index, tbl_widx and tbl_delta are registered and stable for the whole TRAIN cycle.
- Resolution accepted at edge N:
  - busy rises in cycle N+1.
  - With grant held high, weights 0..NW-1 are written in cycles N+1..N+NW.
  - IDLE is reached and res_ready can reassert in cycle N+NW+1.
- A skipped (no-train) resolution allows a back-to-back resolution in the next cycle.
- count and pred_ready update one cycle after the push or pop edge. Pushes continue during TRAIN.

## Test plan
- Reset, then push 4 records without resolving → pred_ready=0 and count=4 after the 4th edge. A 5th pred_valid is dropped.
- Push y=200 with hist=9'h1FF, resolve taken, grant=1 → no training, busy stays 0, mispredict_cnt=0.
- Push y=-5 with hist=9'b000000001 at index 17, resolve taken, grant=1 → 9 consecutive tbl_we at index 17. widx 0 has delta +1; widx 1..8 have delta -1. mispredict_cnt=1, and busy drops after 9 cycles.
- Same as the previous scenario but toggle tbl_grant 1,0,1,0… → writes occur only on grant cycles, widx order 0..8 is preserved, and exactly 9 writes are issued.
- Push and resolve in the same cycle with count=2 → count stays 2. The pop takes the older record (FIFO order checked through tbl_index).
- Deassert reset_n during widx=4 of a training sequence → tbl_we=0 immediately, count=0 and busy=0. No writes occur after reset release.

Source files
------------

// File: rtl/bp_train_scheduler.sv
// Perceptron branch predictor training scheduler: in-order queue of in-flight predictions,
// train decision on resolution, and one +/-1 weight delta per granted table cycle.
module bp_train_scheduler #(
    parameter int NW        = 9,
    parameter int IDXW      = 6,
    parameter int YW        = 16,
    parameter int DEPTH     = 4,
    parameter int THRESHOLD = 133
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_pred_valid,
    output logic                     o_pred_ready,
    input  logic [IDXW-1:0]          i_pred_index,
    input  logic [YW-1:0]            i_pred_y,
    input  logic [NW-1:0]            i_pred_hist,
    input  logic                     i_res_valid,
    output logic                     o_res_ready,
    input  logic                     i_res_taken,
    output logic                     o_tbl_req,
    input  logic                     i_tbl_grant,
    output logic                     o_tbl_we,
    output logic [IDXW-1:0]          o_tbl_index,
    output logic [3:0]               o_tbl_widx,
    output logic [1:0]               o_tbl_delta,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [15:0]              o_mispredict_cnt
);

    localparam int                   PW     = $clog2(DEPTH);
    localparam logic [PW:0]          C_FULL = (PW+1)'(DEPTH);
    localparam logic signed [YW-1:0] C_TH   = YW'(THRESHOLD);
    localparam logic signed [YW-1:0] C_NTH  = -C_TH;
    localparam logic [3:0]           C_LAST = 4'(NW-1);

    typedef enum logic {S_IDLE, S_TRAIN} state_t;
    state_t r_state, w_state_next;

    logic [IDXW-1:0] r_q_index [DEPTH];
    logic [YW-1:0]   r_q_y     [DEPTH];
    logic [NW-1:0]   r_q_hist  [DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [PW:0]     r_count;

    logic [NW-1:0]   r_hist;
    logic            r_taken;
    logic [IDXW-1:0] r_index;
    logic [3:0]      r_widx;
    logic [1:0]      r_delta;
    logic [15:0]     r_mcnt;

    logic                 w_push, w_pop, w_start, w_last;
    logic signed [YW-1:0] w_head_y;
    logic [NW-1:0]        w_head_hist;
    logic                 w_predicted, w_mispredict, w_low_conf, w_train;
    logic [3:0]           w_widx_next;

    // delta = t * x_k, with both t and x_k encoded as 1 => +1, 0 => -1
    function automatic logic [1:0] f_delta(input logic taken, input logic x);
        return (taken == x) ? 2'b01 : 2'b11;
    endfunction

    assign w_head_y     = $signed(r_q_y[r_rptr]);
    assign w_head_hist  = r_q_hist[r_rptr];
    assign w_predicted  = !w_head_y[YW-1] && (w_head_y != '0);
    assign w_mispredict = (i_res_taken != w_predicted);
    assign w_low_conf   = (w_head_y > C_NTH) && (w_head_y < C_TH);
    assign w_train      = w_mispredict || w_low_conf;

    assign o_pred_ready = (r_count != C_FULL);
    assign w_push       = i_pred_valid && o_pred_ready;
    assign w_pop        = i_res_valid && o_res_ready;
    assign w_last       = (r_widx == C_LAST);
    assign w_widx_next  = r_widx + 4'd1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_res_ready  = 1'b0;
        o_busy       = 1'b0;
        o_tbl_req    = 1'b0;
        o_tbl_we     = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_res_ready = (r_count != '0);
                if (i_res_valid && o_res_ready && w_train) begin
                    w_start      = 1'b1;
                    w_state_next = S_TRAIN;
                end
            end
            S_TRAIN: begin
                o_busy    = 1'b1;
                o_tbl_req = 1'b1;
                o_tbl_we  = i_tbl_grant;
                if (i_tbl_grant && w_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Queue payload carries no reset; validity is tracked by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_index[r_wptr] <= i_pred_index;
            r_q_y[r_wptr]     <= i_pred_y;
            r_q_hist[r_wptr]  <= i_pred_hist;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_mcnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
            if (w_pop && w_mispredict && (r_mcnt != 16'hFFFF)) r_mcnt <= r_mcnt + 16'd1;
        end
    end

    // Write address and delta are registered so they hold steady across ungranted cycles.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_index <= '0;
            r_hist  <= '0;
            r_taken <= 1'b0;
            r_widx  <= '0;
            r_delta <= '0;
        end else if (w_start) begin
            r_index <= r_q_index[r_rptr];
            r_hist  <= w_head_hist;
            r_taken <= i_res_taken;
            r_widx  <= '0;
            r_delta <= f_delta(i_res_taken, w_head_hist[0]);
        end else if (o_tbl_we && !w_last) begin
            r_widx  <= w_widx_next;
            r_delta <= f_delta(r_taken, r_hist[w_widx_next]);
        end
    end

    assign o_tbl_index      = r_index;
    assign o_tbl_widx       = r_widx;
    assign o_tbl_delta      = r_delta;
    assign o_count          = r_count;
    assign o_mispredict_cnt = r_mcnt;

endmodule

// File: tb/tb_bp_train_scheduler.sv
// Directed bench for bp_train_scheduler: a reference queue model predicts each
// training write, which a negedge monitor pops and compares.
module tb_bp_train_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pred_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0, tbl_grant = 1'b0;
    logic [5:0]  pred_index = '0;
    logic [15:0] pred_y = '0;
    logic [8:0]  pred_hist = '0;
    logic        pred_ready, res_ready, tbl_req, tbl_we, busy;
    logic [5:0]  tbl_index;
    logic [3:0]  tbl_widx;
    logic [1:0]  tbl_delta;
    logic [2:0]  count;
    logic [15:0] mcnt;

    bp_train_scheduler dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_pred_valid(pred_valid), .o_pred_ready(pred_ready),
        .i_pred_index(pred_index), .i_pred_y(pred_y), .i_pred_hist(pred_hist),
        .i_res_valid(res_valid), .o_res_ready(res_ready), .i_res_taken(res_taken),
        .o_tbl_req(tbl_req), .i_tbl_grant(tbl_grant), .o_tbl_we(tbl_we),
        .o_tbl_index(tbl_index), .o_tbl_widx(tbl_widx), .o_tbl_delta(tbl_delta),
        .o_busy(busy), .o_count(count), .o_mispredict_cnt(mcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] y;
        logic [8:0]  hist;
    } rec_t;

    rec_t        mq[$];
    logic [11:0] sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_wr = 0;
    int          exp_mcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && tbl_we) begin
            n_wr++;
            if (sb.size() == 0) begin
                check("unexpected_write", {20'd0, tbl_index, tbl_widx, tbl_delta}, 32'hFFFF_FFFF);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                check("write", {20'd0, tbl_index, tbl_widx, tbl_delta}, {20'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus: optional push and/or resolve, model updated alongside.
    task automatic step(input logic do_push, input logic [5:0] idx, input logic [15:0] y,
                        input logic [8:0] hist, input logic do_res, input logic taken);
        if (do_push) begin
            pred_valid = 1'b1; pred_index = idx; pred_y = y; pred_hist = hist;
            if (mq.size() < 4) mq.push_back('{idx, y, hist});
        end
        if (do_res) begin
            check("res_ready", {31'd0, res_ready}, {31'd0, mq.size() != 0 && !do_push} | {31'd0, mq.size() > 1});
            res_valid = 1'b1; res_taken = taken;
            if (mq.size() > 0) begin
                rec_t r;
                int   ys;
                logic pred, mis, low;
                r    = mq.pop_front();
                ys   = int'($signed(r.y));
                pred = (ys > 0);
                mis  = (taken != pred);
                low  = (ys > -133) && (ys < 133);
                if (mis) exp_mcnt++;
                if (mis || low)
                    for (int k = 0; k < 9; k++)
                        sb.push_back({r.idx, 4'(k), (taken == r.hist[k]) ? 2'b01 : 2'b11});
            end
        end
        tick();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic wait_idle(input logic toggle);
        int cyc = 0;
        int wr0 = n_wr;
        while (busy && cyc < 40) begin
            tbl_grant = toggle ? (cyc % 2 == 0) : 1'b1;
            tick();
            cyc++;
        end
        tbl_grant = 1'b1;
        check("train_cycles", 32'(cyc), toggle ? 32'd17 : 32'd9);
        check("train_writes", 32'(n_wr - wr0), 32'd9);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int wr_before;
        #3;
        check("rst_pred_ready", {31'd0, pred_ready}, 32'd1);
        check("rst_res_ready",  {31'd0, res_ready},  32'd0);
        check("rst_req_we_busy", {29'd0, tbl_req, tbl_we, busy}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_mcnt", {16'd0, mcnt}, 32'd0);
        check("rst_tbl_fields", {20'd0, tbl_index, tbl_widx, tbl_delta}, 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        tbl_grant = 1'b1;
        tick();

        // fill queue, drop a 5th push
        for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 16'd200, 9'h1FF, 1'b0, 1'b0);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_pred_ready", {31'd0, pred_ready}, 32'd0);
        step(1'b1, 6'd5, 16'd200, 9'h1FF, 1'b0, 1'b0);
        check("drop_count", {29'd0, count}, 32'd4);

        // confident correct predictions: no training, back-to-back resolutions
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b1);
            check("skip_busy", {31'd0, busy}, 32'd0);
        end
        check("skip_count", {29'd0, count}, 32'd0);
        check("skip_mcnt", {16'd0, mcnt}, 32'(exp_mcnt));

        // mispredict at index 17, grant held
        step(1'b1, 6'd17, -16'sd5, 9'b000000001, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("mcnt_1", {16'd0, mcnt}, 32'd1);
        wait_idle(1'b0);

        // low-confidence correct prediction, grant toggling
        step(1'b1, 6'd33, -16'sd5, 9'b101010101, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        check("busy_rise_tog", {31'd0, busy}, 32'd1);
        wait_idle(1'b1);
        check("mcnt_tog", {16'd0, mcnt}, 32'(exp_mcnt));

        // simultaneous push/pop at count 2, FIFO order seen via tbl_index
        step(1'b1, 6'd40, 16'd10, 9'h0A5, 1'b0, 1'b0);
        step(1'b1, 6'd41, 16'd300, 9'h1FF, 1'b0, 1'b0);
        check("pp_count_pre", {29'd0, count}, 32'd2);
        step(1'b1, 6'd42, 16'd300, 9'h15A, 1'b1, 1'b1);
        check("pp_count_post", {29'd0, count}, 32'd2);
        wait_idle(1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        check("pp_skip_busy", {31'd0, busy}, 32'd0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        wait_idle(1'b0);
        check("mcnt_2", {16'd0, mcnt}, 32'(exp_mcnt));

        // reset in the middle of training, with a push during TRAIN
        step(1'b1, 6'd50, -16'sd200, 9'h0F3, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        tick(); tick(); tick();
        step(1'b1, 6'd51, 16'd7, 9'h003, 1'b0, 1'b0);
        check("mid_widx", {28'd0, tbl_widx}, 32'd4);
        check("mid_we", {31'd0, tbl_we}, 32'd1);
        check("mid_count", {29'd0, count}, 32'd1);
        check("mid_mcnt", {16'd0, mcnt}, 32'(exp_mcnt));
        reset_n = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, tbl_we}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_count", {29'd0, count}, 32'd0);
        check("rst_mid_mcnt", {16'd0, mcnt}, 32'd0);
        sb.delete();
        mq.delete();
        exp_mcnt  = 0;
        wr_before = n_wr;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_writes", 32'(n_wr - wr_before), 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_req", {31'd0, tbl_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
